// File: rtl/float_accum_sequencer.sv
// float_accum_sequencer: sums float vectors through an external adder, one add in flight at a time.
// Optional adder-response timeout enabled by defining FLOAT_ACCUM_TIMEOUT_EN.
module float_accum_sequencer #(
  parameter int MAX_WAIT = 64,
  parameter int COUNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        in_value_i,
  input  logic               in_valid_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  output logic [31:0]        add_op1_o,
  output logic [31:0]        add_op2_o,
  output logic               add_input_valid_o,
  input  logic [31:0]        add_result_i,
  input  logic               add_result_valid_i,
  output logic [31:0]        sum_o,
  output logic               sum_valid_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               busy_o,
  output logic               error_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] acc_q, acc_d, op_q, op_d, sum_q, sum_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic open_q, open_d, last_q, last_d, issued_q;
  logic accept, first, capture, timeout;
  assign accept = in_valid_i && state_q == IDLE;
  assign first = accept && !open_q;
  // the adder's valid is still left over from the previous op on the cycle right after issue
  assign capture = state_q == WAIT && !issued_q && add_result_valid_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : open_q ? ISSUE : in_last_i ? DONE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = capture ? (last_q ? DONE : IDLE) : timeout ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
    acc_d = first ? in_value_i : capture ? add_result_i : acc_q;
    op_d = accept && open_q ? in_value_i : op_q;
    last_d = accept && open_q ? in_last_i : last_q;
    open_d = first ? 1'b1 : state_q == DONE ? 1'b0 : open_q;
    count_d = first ? COUNT_W'(1) : capture && count_q != '1 ? count_q + 1'b1 : count_q;
    sum_d = state_q == DONE ? acc_q : sum_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q <= '0;
      op_q <= '0;
      sum_q <= '0;
      count_q <= '0;
      open_q <= 1'b0;
      last_q <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      op_q <= op_d;
      sum_q <= sum_d;
      count_q <= count_d;
      open_q <= open_d;
      last_q <= last_d;
      issued_q <= state_q == ISSUE;
    end
  end
`ifdef FLOAT_ACCUM_TIMEOUT_EN
  localparam int TW = $clog2(MAX_WAIT + 1);
  logic [TW-1:0] tmo_q;
  logic err_q;
  assign timeout = state_q == WAIT && !capture && tmo_q == TW'(MAX_WAIT - 1);
  always_ff @(posedge clk_i) begin
    tmo_q <= rst_i ? '0 : state_q == WAIT ? tmo_q + 1'b1 : '0;
    err_q <= rst_i || first ? 1'b0 : timeout ? 1'b1 : err_q;
  end
  assign error_o = err_q;
`else
  assign timeout = 1'b0 && MAX_WAIT > 0;
  assign error_o = 1'b0;
`endif
  assign in_ready_o = state_q == IDLE;
  assign add_op1_o = acc_q;
  assign add_op2_o = op_q;
  assign add_input_valid_o = state_q == ISSUE;
  assign sum_o = state_q == DONE ? acc_q : sum_q;
  assign sum_valid_o = state_q == DONE;
  assign count_o = count_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_float_accum_sequencer.sv
// tb_float_accum_sequencer: directed checks of the float accumulation sequencer with a hand-driven adder.
module tb_float_accum_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in_value = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [31:0] op1, op2;
  logic add_iv;
  logic [31:0] add_res = '0;
  logic add_rv = 1'b0;
  logic [31:0] sum;
  logic sum_valid;
  logic [7:0] count;
  logic busy, error;
  int tests = 0;
  int fails = 0;
  int issues = 0;
  int pulses = 0;
  int snap;

  float_accum_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .in_value_i(in_value), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .add_op1_o(op1), .add_op2_o(op2), .add_input_valid_o(add_iv),
    .add_result_i(add_res), .add_result_valid_i(add_rv),
    .sum_o(sum), .sum_valid_o(sum_valid), .count_o(count), .busy_o(busy), .error_o(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (add_iv) issues <= issues + 1;
    if (sum_valid) pulses <= pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_sum_valid", {31'b0, sum_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_count", {24'b0, count}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_op1", op1, 32'd0);
    check("rst_op2", op2, 32'd0);
    check("rst_add_iv", {31'b0, add_iv}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);

    // single element vector 3.0
    in_value = 32'h40400000; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("single_sum_valid", {31'b0, sum_valid}, 32'd1);
    check("single_sum", sum, 32'h40400000);
    check("single_count", {24'b0, count}, 32'd1);
    check("single_no_issue", issues, 32'd0);
    tick();
    check("single_pulse_end", {31'b0, sum_valid}, 32'd0);
    check("single_sum_hold", sum, 32'h40400000);
    check("single_count_hold", {24'b0, count}, 32'd1);
    check("single_idle", {31'b0, busy}, 32'd0);

    // vector 1, 2, 3 with a 3-cycle adder
    in_value = 32'h3F800000; in_valid = 1'b1;
    tick();
    check("vec_first_count", {24'b0, count}, 32'd1);
    check("vec_first_ready", {31'b0, in_ready}, 32'd1);
    in_value = 32'h40000000;
    tick();
    in_valid = 1'b0;
    check("vec_issue1_iv", {31'b0, add_iv}, 32'd1);
    check("vec_issue1_ready", {31'b0, in_ready}, 32'd0);
    check("vec_issue1_op1", op1, 32'h3F800000);
    check("vec_issue1_op2", op2, 32'h40000000);
    tick();
    tick();
    check("vec_wait_iv", {31'b0, add_iv}, 32'd0);
    check("vec_wait_op1", op1, 32'h3F800000);
    check("vec_wait_op2", op2, 32'h40000000);
    tick();
    add_res = 32'h40400000; add_rv = 1'b1;
    tick();
    add_rv = 1'b0;
    check("vec_cap1_busy", {31'b0, busy}, 32'd0);
    check("vec_cap1_count", {24'b0, count}, 32'd2);
    in_value = 32'h40400000; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("vec_issue2_iv", {31'b0, add_iv}, 32'd1);
    check("vec_issue2_op1", op1, 32'h40400000);
    check("vec_issue2_op2", op2, 32'h40400000);
    tick();
    tick();
    tick();
    add_res = 32'h40C00000; add_rv = 1'b1;
    tick();
    add_rv = 1'b0;
    check("vec_done_valid", {31'b0, sum_valid}, 32'd1);
    check("vec_done_sum", sum, 32'h40C00000);
    check("vec_done_count", {24'b0, count}, 32'd3);
    check("vec_two_issues", issues, 32'd2);
    tick();

    // stale adder valid on first WAIT cycle, upstream valid held through ISSUE/WAIT
    in_value = 32'h40A00000; in_valid = 1'b1;
    tick();
    in_value = 32'h3F800000;
    tick();
    in_value = 32'h40000000; in_last = 1'b1;
    add_res = 32'hDEADBEEF; add_rv = 1'b1;
    check("held_issue_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("held_wait1_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("stale_not_captured", {31'b0, busy}, 32'd1);
    check("stale_count", {24'b0, count}, 32'd1);
    check("stale_acc", op1, 32'h40A00000);
    add_res = 32'h40C00000;
    tick();
    add_rv = 1'b0;
    check("fresh_ready", {31'b0, in_ready}, 32'd1);
    check("fresh_count", {24'b0, count}, 32'd2);
    check("fresh_acc", op1, 32'h40C00000);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("held_accept_iv", {31'b0, add_iv}, 32'd1);
    check("held_accept_op2", op2, 32'h40000000);
    tick();
    tick();
    add_res = 32'h41000000; add_rv = 1'b1;
    tick();
    add_rv = 1'b0;
    check("held_done_valid", {31'b0, sum_valid}, 32'd1);
    check("held_done_sum", sum, 32'h41000000);
    check("held_done_count", {24'b0, count}, 32'd3);
    tick();

    // reset while waiting on the adder
    in_value = 32'h3F800000; in_valid = 1'b1;
    tick();
    in_value = 32'h40000000;
    tick();
    in_valid = 1'b0;
    tick();
    snap = pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    add_res = 32'h12345678; add_rv = 1'b1;
    tick();
    add_rv = 1'b0;
    check("midrst_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_sum_valid", {31'b0, sum_valid}, 32'd0);
    check("midrst_count", {24'b0, count}, 32'd0);
    check("midrst_acc", op1, 32'd0);
    tick();
    check("midrst_no_pulse", pulses, snap);
    in_value = 32'h40400000; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("midrst_first_again", {31'b0, sum_valid}, 32'd1);
    check("midrst_first_sum", sum, 32'h40400000);
    check("midrst_first_count", {24'b0, count}, 32'd1);
    tick();

    in_value = 32'h3F800000; in_valid = 1'b1;
    tick();
    in_value = 32'h40000000;
    tick();
    in_valid = 1'b0;
    tick();
`ifdef FLOAT_ACCUM_TIMEOUT_EN
    repeat (63) tick();
    check("tmo_before_valid", {31'b0, sum_valid}, 32'd0);
    check("tmo_before_err", {31'b0, error}, 32'd0);
    tick();
    check("tmo_err", {31'b0, error}, 32'd1);
    check("tmo_valid", {31'b0, sum_valid}, 32'd1);
    check("tmo_partial", sum, 32'h3F800000);
    check("tmo_count", {24'b0, count}, 32'd1);
    tick();
    check("tmo_err_sticky", {31'b0, error}, 32'd1);
    in_value = 32'h40400000; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("tmo_err_cleared", {31'b0, error}, 32'd0);
    check("tmo_next_sum", sum, 32'h40400000);
    tick();
`else
    snap = pulses;
    repeat (100) tick();
    check("nowait_busy", {31'b0, busy}, 32'd1);
    check("nowait_err", {31'b0, error}, 32'd0);
    check("nowait_no_pulse", pulses, snap);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("nowait_rst_idle", {31'b0, busy}, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/float_accum_sequencer.md
FLOAT_ACCUM_SEQUENCER -- requirements
Module: float_accum_sequencer

Interface
REQ-001 SHALL provide parameter MAX_WAIT, default 64, the adder-response timeout in cycles (used only with FLOAT_ACCUM_TIMEOUT_EN).
REQ-002 SHALL provide parameter COUNT_W, default 8, the width of the element counter.
REQ-003 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 InValue  in  32 (float: sign, exponent[7:0], mantissa[22:0])  upstream operand.
REQ-006 InValid  in  1  InValue/InLast valid.
REQ-007 InLast  in  1  marks final element of the current vector.
REQ-008 InReady  out  1  sequencer accepts an element this cycle.
REQ-009 AddOp1  out  32 float  running sum presented to the adder.
REQ-010 AddOp2  out  32 float  new element presented to the adder.
REQ-011 AddInputValid  out  1  one-cycle issue strobe to the adder's InputValid.
REQ-012 AddResult  in  32 float  adder Result.
REQ-013 AddResultValid  in  1  adder ResultValid.
REQ-014 Sum  out  32 float  completed vector sum.
REQ-015 SumValid  out  1  one-cycle pulse; Sum valid.
REQ-016 Count  out  COUNT_W  elements accumulated in the current or last vector.
REQ-017 Busy  out  1  high in any state other than IDLE.
REQ-018 Error  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and DONE.
REQ-020 InReady SHALL equal 1 only in IDLE; an accept is InValid && InReady.
REQ-021 On an accept with no vector open (first element), the block SHALL load the accumulator directly with InValue, set Count=1 and open the vector, without using the adder.
- With InLast=1 it SHALL go to DONE; otherwise it SHALL stay in IDLE.
REQ-022 On an accept with a vector open, the block SHALL latch InValue into the operand register and InLast into a last-pending flag, then go to ISSUE.
REQ-023 In ISSUE, AddInputValid SHALL be 1 for exactly that one cycle, with AddOp1=accumulator and AddOp2=operand register; the next state SHALL be WAIT.
REQ-024 AddOp1 and AddOp2 SHALL stay stable from ISSUE until the result is captured.
REQ-025 In the first WAIT cycle the block SHALL ignore AddResultValid, which is stale from the previous operation.
REQ-026 In any later WAIT cycle with AddResultValid=1, the block SHALL set the accumulator to AddResult and increment Count, saturating at 2^COUNT_W-1.
- With last-pending set, the next state SHALL be DONE; otherwise it SHALL be IDLE.
REQ-027 In DONE, the block SHALL drive SumValid=1 and Sum=accumulator for one cycle, close the vector and return to IDLE.
REQ-028 Sum SHALL hold its value until the next DONE.
REQ-029 Count SHALL hold its value after DONE until the first element of the next vector is accepted.
REQ-030 AddResultValid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-031 Sign, exponent and mantissa fields SHALL pass unmodified; the block performs no arithmetic on floats.
REQ-032 Latency from an accepted single-element vector to SumValid SHALL be 1 cycle.
REQ-033 For subsequent elements, latency SHALL be 2 cycles plus the adder latency to result capture, plus 1 cycle to SumValid if the element is last.

Reset
REQ-034 On Reset, the block SHALL go to IDLE and clear the open-vector flag, last-pending flag and timeout counter.
REQ-035 On Reset, every output SHALL be 0: AddInputValid, SumValid, Busy, Error, Count, Sum, AddOp1 and AddOp2; InReady SHALL be 1 from the first cycle after Reset deasserts.
REQ-036 Reset mid-operation (ISSUE/WAIT) SHALL abandon the in-flight add; a later AddResultValid SHALL have no effect.

Configuration
REQ-037 With macro FLOAT_ACCUM_TIMEOUT_EN defined, a counter SHALL run in WAIT.
- If AddResultValid is not captured within MAX_WAIT cycles of entering WAIT, Error SHALL be set and the FSM SHALL go to DONE, emitting the partial accumulator on Sum with a SumValid pulse.
- Error SHALL clear on Reset or on the next first-element accept.
REQ-038 Without FLOAT_ACCUM_TIMEOUT_EN, Error SHALL be tied to 0 and WAIT SHALL persist indefinitely.

Verification
REQ-039 Single element 0x40400000 (3.0) with InLast=1 -> SumValid 1 cycle after accept, Sum=0x40400000, Count=1, AddInputValid never asserted.
REQ-040 Vector 0x3F800000, 0x40000000, 0x40400000 (1, 2, 3) with a behavioural 3-cycle adder -> two AddInputValid pulses; second pulse carries AddOp1=0x40400000 and AddOp2=0x40400000; Sum=0x40C00000, Count=3.
REQ-041 AddResultValid held high from the previous op during the first WAIT cycle -> not captured; the capture uses the fresh result only.
REQ-042 Reset asserted in WAIT, then AddResultValid pulse -> FSM in IDLE, InReady=1, SumValid stays 0, Count=0.
REQ-043 With FLOAT_ACCUM_TIMEOUT_EN and MAX_WAIT=64, adder silent -> Error=1 and SumValid after 64 WAIT cycles, Sum=partial accumulator; next first element clears Error.
REQ-044 InValid held high during ISSUE/WAIT -> no extra accepts (InReady=0); the element is accepted on return to IDLE.
